// File: rtl/sd_pulse_spacer.sv
// Event-rate conditioner: counts incoming single-cycle events and re-emits them
// as single-cycle pulses spaced exactly `gap` cycles apart while backlog exists.
module sd_pulse_spacer #(
  parameter int width = 4,
  parameter int gap   = 8,
  parameter int tw    = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pulse_in,
  input  logic             ovf_clr,
  output logic             pulse_out,
  output logic [width-1:0] pending,
  output logic             overflow
);

  typedef enum logic {IDLE, SPACE} state_t;

  localparam logic [width-1:0] CAP    = '1;
  // SPACE lasts gap-1 cycles; the timer counts down to zero inclusive.
  localparam logic [tw-1:0]    RELOAD = tw'(gap - 2);

  state_t           state_q, state_d;
  logic [tw-1:0]    timer_q, timer_d;
  logic             pulse_out_q, pulse_out_d;
  logic [width-1:0] pending_q, pending_d;
  logic             overflow_q, overflow_d;
  logic             emit;
  logic             drop;

  // Saturating update of the backlog count; an increment at full is discarded.
  function automatic logic [width-1:0] sat_step(input logic [width-1:0] cnt,
                                                input logic inc,
                                                input logic dec);
    logic [width-1:0] res;
    res = cnt;
    if (inc && !dec) begin
      if (cnt != CAP) res = cnt + 1'b1;
    end else if (dec && !inc) begin
      if (cnt != '0) res = cnt - 1'b1;
    end
    return res;
  endfunction

  always_comb begin
    emit        = (state_q == IDLE) && ((pending_q != '0) || pulse_in);
    drop        = pulse_in && !emit && (pending_q == CAP);
    pulse_out_d = emit;
    pending_d   = sat_step(pending_q, pulse_in, emit);
    overflow_d  = overflow_q;
    if (drop)         overflow_d = 1'b1;
    else if (ovf_clr) overflow_d = 1'b0;
    state_d = state_q;
    timer_d = timer_q;
    if (emit) begin
      state_d = SPACE;
      timer_d = RELOAD;
    end else if (state_q == SPACE) begin
      if (timer_q == '0) state_d = IDLE;
      else               timer_d = timer_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      timer_q     <= '0;
      pulse_out_q <= 1'b0;
      pending_q   <= '0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      pulse_out_q <= pulse_out_d;
      pending_q   <= pending_d;
      overflow_q  <= overflow_d;
    end
  end

  assign pulse_out = pulse_out_q;
  assign pending   = pending_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_sd_pulse_spacer.sv
// Bench for sd_pulse_spacer: three configurations share one stimulus stream and
// are compared cycle by cycle against a timestamp-based reference model.
module tb_sd_pulse_spacer;

  logic clk = 1'b0;
  logic reset, pulse_in, ovf_clr;
  logic       po0, po1, po2;
  logic [3:0] pd0;
  logic [1:0] pd1;
  logic [2:0] pd2;
  logic       of0, of1, of2;

  always #5 clk = ~clk;

  sd_pulse_spacer #(.width(4), .gap(8), .tw(4)) u_dut0 (
    .clk(clk), .reset(reset), .pulse_in(pulse_in), .ovf_clr(ovf_clr),
    .pulse_out(po0), .pending(pd0), .overflow(of0));
  sd_pulse_spacer #(.width(2), .gap(8), .tw(4)) u_dut1 (
    .clk(clk), .reset(reset), .pulse_in(pulse_in), .ovf_clr(ovf_clr),
    .pulse_out(po1), .pending(pd1), .overflow(of1));
  sd_pulse_spacer #(.width(3), .gap(2), .tw(4)) u_dut2 (
    .clk(clk), .reset(reset), .pulse_in(pulse_in), .ovf_clr(ovf_clr),
    .pulse_out(po2), .pending(pd2), .overflow(of2));

  int gaps[3] = '{8, 8, 2};
  int caps[3] = '{15, 3, 7};

  int m_pend[3], m_nok[3], m_ovf[3], m_pout[3];
  int last_pulse[3];
  bit have_last[3];
  int cyc = 0;
  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s @cycle %0d: got %0d expected %0d", tag, cyc, obs, exp);
    end
  endtask

  // Reference: an emission is allowed once `gap` cycles have elapsed since the
  // previous one; the backlog is plain integer arithmetic clipped at capacity.
  task automatic model(input bit pin, input bit clr, input bit rst);
    for (int k = 0; k < 3; k++) begin
      bit e;
      bit dr;
      int t;
      if (rst) begin
        m_pend[k] = 0; m_ovf[k] = 0; m_pout[k] = 0; m_nok[k] = cyc + 1;
      end else begin
        e  = (cyc >= m_nok[k]) && (m_pend[k] > 0 || pin);
        t  = m_pend[k] + int'(pin) - int'(e);
        dr = (t > caps[k]);
        if (dr) t = caps[k];
        m_pend[k] = t;
        if (dr)       m_ovf[k] = 1;
        else if (clr) m_ovf[k] = 0;
        m_pout[k] = int'(e);
        if (e) m_nok[k] = cyc + gaps[k];
      end
    end
  endtask

  task automatic step(input bit pin, input bit clr, input bit rst);
    int po[3], pd[3], ov[3];
    pulse_in = pin;
    ovf_clr  = clr;
    reset    = rst;
    model(pin, clr, rst);
    @(posedge clk);
    #1;
    po = '{int'(po0), int'(po1), int'(po2)};
    pd = '{int'(pd0), int'(pd1), int'(pd2)};
    ov = '{int'(of0), int'(of1), int'(of2)};
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("pulse_out[%0d]", k), po[k], m_pout[k]);
      chk($sformatf("pending[%0d]", k), pd[k], m_pend[k]);
      chk($sformatf("overflow[%0d]", k), ov[k], m_ovf[k]);
      if (rst) have_last[k] = 0;
      else if (po[k] == 1) begin
        if (have_last[k])
          chk($sformatf("spacing_ok[%0d]", k), int'((cyc - last_pulse[k]) >= gaps[k]), 1);
        have_last[k]  = 1;
        last_pulse[k] = cyc;
      end
    end
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0);
  endtask

  initial begin
    pulse_in = 0; ovf_clr = 0; reset = 1;
    step(0, 0, 1);
    step(0, 0, 1);
    chk("reset_pending0", int'(pd0), 0);
    chk("reset_pout0", int'(po0), 0);

    // single pulse: immediate emission
    step(1, 0, 0);
    chk("single_pout0", int'(po0), 1);
    chk("single_pend0", int'(pd0), 0);
    idle(12);

    // burst of three
    step(1, 0, 0); step(1, 0, 0); step(1, 0, 0);
    chk("burst_pend0", int'(pd0), 2);
    idle(30);

    // saturation of the width-2 instance, clear coinciding with a drop
    for (int i = 0; i < 5; i++) step(1, 0, 0);
    step(1, 1, 0);
    chk("sat_pend1", int'(pd1), 3);
    chk("sat_ovf_hold1", int'(of1), 1);
    idle(30);
    chk("sat_drained1", int'(pd1), 0);
    step(0, 1, 0);
    chk("ovf_cleared1", int'(of1), 0);

    // reset in the middle of a backlog
    step(1, 0, 0); step(1, 0, 0); step(1, 0, 0); step(0, 0, 0);
    step(0, 0, 1);
    chk("midrst_pend0", int'(pd0), 0);
    chk("midrst_pout0", int'(po0), 0);
    idle(10);
    step(1, 0, 0);
    chk("postrst_pout0", int'(po0), 1);
    idle(20);

    // continuous input
    for (int i = 0; i < 40; i++) step(1, 0, 0);
    chk("cont_sat_pend2", int'(pd2), 7);
    chk("cont_ovf2", int'(of2), 1);
    idle(150);
    step(0, 1, 0);

    // randomized traffic with varying density
    for (int blk = 0; blk < 20; blk++) begin
      int dens;
      dens = $urandom_range(1, 6);
      for (int i = 0; i < 150; i++)
        step($urandom_range(0, dens - 1) == 0, $urandom_range(0, 15) == 0,
             $urandom_range(0, 299) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
